// File: rtl/d16_mem_pkg.sv
// Shared types, address-mapping widths and lane helpers for the d16 data-memory front end.
package d16_mem_pkg;

  localparam int CPU_ADDR_W   = 16;
  localparam int CPU_DATA_W   = 16;
  localparam int MEM_ADDR_W   = 24;
  localparam int MEM_DATA_W   = 32;
  localparam int MEM_ADDR_PAD = MEM_ADDR_W - (CPU_ADDR_W - 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_DONE
  } state_e;

  // Bit offset of the addressed lane; halfwords ignore addr[0].
  function automatic logic [4:0] lane_lsb(input logic [1:0] lane, input logic is_byte);
    return is_byte ? {lane, 3'b000} : {lane[1], 4'b0000};
  endfunction

  function automatic logic [CPU_DATA_W-1:0] lane_extract(
    input logic [MEM_DATA_W-1:0] word,
    input logic [1:0]            lane,
    input logic                  is_byte
  );
    logic [MEM_DATA_W-1:0] shifted;
    shifted = word >> lane_lsb(lane, is_byte);
    return is_byte ? {8'h00, shifted[7:0]} : shifted[15:0];
  endfunction

  function automatic logic [MEM_DATA_W-1:0] lane_merge(
    input logic [MEM_DATA_W-1:0] word,
    input logic [1:0]            lane,
    input logic                  is_byte,
    input logic [CPU_DATA_W-1:0] wdata
  );
    logic [MEM_DATA_W-1:0] mask;
    logic [MEM_DATA_W-1:0] data;
    mask = (is_byte ? 32'h0000_00FF : 32'h0000_FFFF) << lane_lsb(lane, is_byte);
    data = (is_byte ? {24'h00_0000, wdata[7:0]} : {16'h0000, wdata}) << lane_lsb(lane, is_byte);
    return (word & ~mask) | (data & mask);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// CPU request bus and DRAM port-2 bus of the data-memory front end.
interface mem_access_unit_if;
  import d16_mem_pkg::*;

  logic                  cpu_req;
  logic                  cpu_we;
  logic                  cpu_byte;
  logic [CPU_ADDR_W-1:0] cpu_addr;
  logic [CPU_DATA_W-1:0] cpu_wdata;
  logic [CPU_DATA_W-1:0] cpu_rdata;
  logic                  cpu_busy;
  logic                  cpu_done;
  logic                  cpu_err;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [MEM_DATA_W-1:0] mem_wdata;
  logic [MEM_DATA_W-1:0] mem_rdata;
  logic                  mem_req_read;
  logic                  mem_req_write;
  logic                  mem_data_valid;
  logic                  mem_write_complete;

  // The front end itself.
  modport slave (
    input  cpu_req, cpu_we, cpu_byte, cpu_addr, cpu_wdata,
    input  mem_rdata, mem_data_valid, mem_write_complete,
    output cpu_rdata, cpu_busy, cpu_done, cpu_err,
    output mem_addr, mem_wdata, mem_req_read, mem_req_write
  );

  // The surrounding core and DRAM arbiter.
  modport master (
    output cpu_req, cpu_we, cpu_byte, cpu_addr, cpu_wdata,
    output mem_rdata, mem_data_valid, mem_write_complete,
    input  cpu_rdata, cpu_busy, cpu_done, cpu_err,
    input  mem_addr, mem_wdata, mem_req_read, mem_req_write
  );

endinterface

// File: rtl/mem_access_unit_byte_lane_merge.sv
// Combinational lane extract (zero-extended load) and lane merge (read-modify-write store).
module byte_lane_merge
  import d16_mem_pkg::*;
(
  input  logic [MEM_DATA_W-1:0] word,
  input  logic [1:0]            lane,
  input  logic                  is_byte,
  input  logic [CPU_DATA_W-1:0] wdata,
  output logic [CPU_DATA_W-1:0] rdata,
  output logic [MEM_DATA_W-1:0] merged
);

  assign rdata  = lane_extract(word, lane, is_byte);
  assign merged = lane_merge(word, lane, is_byte, wdata);

endmodule

// File: rtl/mem_access_unit.sv
// Converts 16-bit byte/halfword CPU loads and stores into 32-bit DRAM word transactions,
// with read-modify-write for stores and a watchdog on unanswered DRAM requests.
module mem_access_unit
  import d16_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_unit_if.slave  bus
);

  localparam int unsigned WDOG_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e state_q, state_d;

  logic [CPU_ADDR_W-1:0] addr_q;
  logic                  we_q;
  logic                  byte_q;
  logic [CPU_DATA_W-1:0] wdata_q;
  logic [CPU_DATA_W-1:0] rdata_q;
  logic [MEM_DATA_W-1:0] mem_wdata_q;
  logic [WDOG_W-1:0]     wdog_q, wdog_d;
  logic                  busy_q, done_q, err_q, rd_q, wr_q;
  logic                  err_d;

  logic                  accept;
  logic                  rd_hit;
  logic                  timeout_hit;
  logic [CPU_DATA_W-1:0] lane_rdata;
  logic [MEM_DATA_W-1:0] lane_merged;

  byte_lane_merge u_lane (
    .word    (bus.mem_rdata),
    .lane    (addr_q[1:0]),
    .is_byte (byte_q),
    .wdata   (wdata_q),
    .rdata   (lane_rdata),
    .merged  (lane_merged)
  );

  assign accept      = (state_q == ST_IDLE) && bus.cpu_req;
  assign rd_hit      = (state_q == ST_RD_WAIT) && bus.mem_data_valid;
  assign timeout_hit = (TIMEOUT != 0) && (wdog_q == WDOG_LAST);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d = state_q;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE:    if (bus.cpu_req) state_d = ST_RD_REQ;
      ST_RD_REQ:  state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        // Data-valid wins over a simultaneous stray write-complete.
        if (bus.mem_data_valid) begin
          state_d = we_q ? ST_WR_REQ : ST_DONE;
        end else if (timeout_hit) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end
      end
      ST_WR_REQ:  state_d = ST_WR_WAIT;
      ST_WR_WAIT: begin
        if (bus.mem_write_complete) begin
          state_d = ST_DONE;
        end else if (timeout_hit) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end
      end
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    // Counter holds the number of cycles already spent in the current wait state.
    wdog_d = '0;
    if ((state_q == ST_RD_WAIT || state_q == ST_WR_WAIT) && state_d == state_q) begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      byte_q      <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      mem_wdata_q <= '0;
      wdog_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
      err_q   <= err_d;
      rd_q    <= (state_d == ST_RD_REQ);
      wr_q    <= (state_d == ST_WR_REQ);

      if (accept) begin
        addr_q  <= bus.cpu_addr;
        we_q    <= bus.cpu_we;
        byte_q  <= bus.cpu_byte;
        wdata_q <= bus.cpu_wdata;
      end

      if (rd_hit && !we_q) rdata_q     <= lane_rdata;
      if (rd_hit && we_q)  mem_wdata_q <= lane_merged;
    end
  end

  assign bus.cpu_rdata     = rdata_q;
  assign bus.cpu_busy      = busy_q;
  assign bus.cpu_done      = done_q;
  assign bus.cpu_err       = err_q;
  assign bus.mem_addr      = {{MEM_ADDR_PAD{1'b0}}, addr_q[CPU_ADDR_W-1:2]};
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.mem_req_read  = rd_q;
  assign bus.mem_req_write = wr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomized bench for mem_access_unit against a byte-array reference model.
module tb_mem_access_unit;

  localparam int unsigned TB_TIMEOUT = 8;

  logic clk;
  logic rst_n;

  mem_access_unit_if bus();

  mem_access_unit #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  int rd_pulses   = 0;
  int wr_pulses   = 0;
  int done_pulses = 0;

  logic [15:0] exp_rdata;
  logic [31:0] exp_wdata;

  always @(negedge clk) begin
    rd_pulses   <= rd_pulses   + int'(bus.mem_req_read);
    wr_pulses   <= wr_pulses   + int'(bus.mem_req_write);
    done_pulses <= done_pulses + int'(bus.cpu_done);
  end

  initial begin
    #500000;
    $display("FAIL sim_timeout: observed no finish, expected finish within bound");
    $fatal(1, "bench did not terminate");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: the DRAM word viewed as four little-endian bytes.
  function automatic logic [15:0] model_load(input logic [31:0] word, input logic [15:0] addr,
                                             input logic is_byte);
    logic [7:0] b [4];
    for (int k = 0; k < 4; k++) b[k] = word[8*k +: 8];
    if (is_byte) return {8'h00, b[addr[1:0]]};
    return {b[{addr[1], 1'b1}], b[{addr[1], 1'b0}]};
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] word, input logic [15:0] addr,
                                              input logic is_byte, input logic [15:0] wdata);
    logic [7:0] b [4];
    for (int k = 0; k < 4; k++) b[k] = word[8*k +: 8];
    if (is_byte) begin
      b[addr[1:0]] = wdata[7:0];
    end else begin
      b[{addr[1], 1'b0}] = wdata[7:0];
      b[{addr[1], 1'b1}] = wdata[15:8];
    end
    return {b[3], b[2], b[1], b[0]};
  endfunction

  task automatic scramble();
    bus.cpu_req   = 1'($urandom);
    bus.cpu_we    = 1'($urandom);
    bus.cpu_byte  = 1'($urandom);
    bus.cpu_addr  = 16'($urandom);
    bus.cpu_wdata = 16'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "/rdata"},  32'(bus.cpu_rdata), 32'h0);
    check({tag, "/wdata"},  bus.mem_wdata, 32'h0);
    check({tag, "/addr"},   32'(bus.mem_addr), 32'h0);
    check({tag, "/done"},   32'(bus.cpu_done), 32'h0);
    check({tag, "/err"},    32'(bus.cpu_err), 32'h0);
    check({tag, "/busy"},   32'(bus.cpu_busy), 32'h0);
    check({tag, "/rd_req"}, 32'(bus.mem_req_read), 32'h0);
    check({tag, "/wr_req"}, 32'(bus.mem_req_write), 32'h0);
  endtask

  // Called at the negedge of an idle cycle; returns at the negedge of the idle cycle after DONE.
  // silent: 0 = DRAM answers, 1 = read never answered, 2 = write never answered.
  task automatic run_op(input string tag, input logic we, input logic is_byte,
                        input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [31:0] word, input int rd_lat, input int wr_lat,
                        input int silent);
    int rd0, wr0, dn0, cnt;
    logic [31:0] exp_addr;
    rd0 = rd_pulses;
    wr0 = wr_pulses;
    dn0 = done_pulses;
    exp_addr = {18'h0, addr[15:2]};

    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_byte  = is_byte;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;

    @(negedge clk);
    scramble();
    check({tag, "/rd_pulse"}, 32'(bus.mem_req_read), 32'h1);
    check({tag, "/mem_addr"}, 32'(bus.mem_addr), exp_addr);
    check({tag, "/busy"},     32'(bus.cpu_busy), 32'h1);

    if (silent == 1) begin
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
        scramble();
        bus.mem_write_complete = 1'($urandom);
      end while (bus.cpu_done !== 1'b1 && cnt < 50);
      check({tag, "/rd_abort_cycles"}, 32'(cnt), 32'(TB_TIMEOUT + 1));
      check({tag, "/rd_abort_err"},    32'(bus.cpu_err), 32'h1);
      check({tag, "/rd_abort_rdata"},  32'(bus.cpu_rdata), 32'(exp_rdata));
    end else begin
      for (int i = 1; i <= rd_lat; i++) begin
        @(negedge clk);
        scramble();
        bus.mem_write_complete = 1'($urandom);
      end
      bus.mem_data_valid = 1'b1;
      bus.mem_rdata      = word;

      @(negedge clk);
      bus.mem_data_valid     = 1'b0;
      bus.mem_write_complete = 1'b0;
      bus.mem_rdata          = $urandom;
      scramble();
      if (!we) begin
        exp_rdata = model_load(word, addr, is_byte);
        check({tag, "/ld_done"},  32'(bus.cpu_done), 32'h1);
        check({tag, "/ld_err"},   32'(bus.cpu_err), 32'h0);
        check({tag, "/ld_rdata"}, 32'(bus.cpu_rdata), 32'(exp_rdata));
        check({tag, "/ld_addr"},  32'(bus.mem_addr), exp_addr);
      end else begin
        exp_wdata = model_store(word, addr, is_byte, wdata);
        check({tag, "/wr_pulse"}, 32'(bus.mem_req_write), 32'h1);
        check({tag, "/wdata"},    bus.mem_wdata, exp_wdata);
        check({tag, "/no_early_done"}, 32'(bus.cpu_done), 32'h0);
        if (silent == 2) begin
          cnt = 0;
          do begin
            @(negedge clk);
            cnt++;
            scramble();
            bus.mem_data_valid = 1'($urandom);
          end while (bus.cpu_done !== 1'b1 && cnt < 50);
          check({tag, "/wr_abort_cycles"}, 32'(cnt), 32'(TB_TIMEOUT + 1));
          check({tag, "/wr_abort_err"},    32'(bus.cpu_err), 32'h1);
        end else begin
          for (int i = 1; i <= wr_lat; i++) begin
            @(negedge clk);
            scramble();
            bus.mem_data_valid = 1'($urandom);
          end
          bus.mem_write_complete = 1'b1;
          @(negedge clk);
          bus.mem_write_complete = 1'b0;
          bus.mem_data_valid     = 1'b0;
          scramble();
          check({tag, "/st_done"},  32'(bus.cpu_done), 32'h1);
          check({tag, "/st_err"},   32'(bus.cpu_err), 32'h0);
          check({tag, "/st_rdata"}, 32'(bus.cpu_rdata), 32'(exp_rdata));
          check({tag, "/st_addr"},  32'(bus.mem_addr), exp_addr);
        end
      end
    end

    @(negedge clk);
    bus.cpu_req            = 1'b0;
    bus.mem_data_valid     = 1'b0;
    bus.mem_write_complete = 1'b0;
    check({tag, "/idle_busy"}, 32'(bus.cpu_busy), 32'h0);
    check({tag, "/idle_done"}, 32'(bus.cpu_done), 32'h0);
    check({tag, "/idle_err"},  32'(bus.cpu_err), 32'h0);
    check({tag, "/n_rd"},   32'(rd_pulses - rd0), 32'h1);
    check({tag, "/n_wr"},   32'(wr_pulses - wr0), (we && silent != 1) ? 32'h1 : 32'h0);
    check({tag, "/n_done"}, 32'(done_pulses - dn0), 32'h1);
  endtask

  initial begin
    int dn0;
    logic        r_we, r_byte;
    logic [15:0] r_addr, r_wdata;
    logic [31:0] r_word;
    int          r_silent;

    exp_rdata = '0;
    exp_wdata = '0;
    rst_n                  = 1'b0;
    bus.cpu_req            = 1'b0;
    bus.cpu_we             = 1'b0;
    bus.cpu_byte           = 1'b0;
    bus.cpu_addr           = '0;
    bus.cpu_wdata          = '0;
    bus.mem_rdata          = '0;
    bus.mem_data_valid     = 1'b0;
    bus.mem_write_complete = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_busy", 32'(bus.cpu_busy), 32'h0);

    run_op("hw_load",  1'b0, 1'b0, 16'h0006, 16'h0000, 32'hAABBCCDD, 2, 1, 0);
    run_op("b_load",   1'b0, 1'b1, 16'h0011, 16'h0000, 32'h11223344, 1, 1, 0);
    run_op("b_store",  1'b1, 1'b1, 16'h0003, 16'h005A, 32'h01020304, 3, 2, 0);
    run_op("hw_store", 1'b1, 1'b0, 16'h0000, 16'hBEEF, 32'hFFFF0000, 2, 4, 0);
    run_op("late_ok",  1'b0, 1'b0, 16'h0003, 16'h0000, 32'h13579BDF, 8, 1, 0);
    run_op("rd_tmo",   1'b0, 1'b1, 16'h1236, 16'h0000, 32'h0, 1, 1, 1);

    // A DRAM answer arriving after the abort must not disturb anything.
    bus.mem_data_valid = 1'b1;
    bus.mem_rdata      = 32'hDEADBEEF;
    dn0 = done_pulses;
    @(negedge clk);
    bus.mem_data_valid = 1'b0;
    check("late_valid_busy",  32'(bus.cpu_busy), 32'h0);
    check("late_valid_rdata", 32'(bus.cpu_rdata), 32'(exp_rdata));
    @(negedge clk);
    check("late_valid_done",  32'(done_pulses - dn0), 32'h0);

    run_op("wr_tmo",   1'b1, 1'b0, 16'h2222, 16'h4321, 32'h89ABCDEF, 2, 1, 2);

    // Reset asserted while the store sits in WR_WAIT.
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_byte  = 1'b1;
    bus.cpu_addr  = 16'h0102;
    bus.cpu_wdata = 16'h0077;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    @(negedge clk);
    bus.mem_data_valid = 1'b1;
    bus.mem_rdata      = 32'h89ABCDEF;
    @(negedge clk);
    bus.mem_data_valid = 1'b0;
    check("rst_mid/wr_pulse", 32'(bus.mem_req_write), 32'h1);
    check("rst_mid/wdata", bus.mem_wdata, model_store(32'h89ABCDEF, 16'h0102, 1'b1, 16'h0077));
    @(negedge clk);
    check("rst_mid/busy", 32'(bus.cpu_busy), 32'h1);
    rst_n = 1'b0;
    dn0 = done_pulses;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    exp_rdata = '0;
    exp_wdata = '0;
    rst_n = 1'b1;
    bus.mem_write_complete = 1'b1;
    @(negedge clk);
    bus.mem_write_complete = 1'b0;
    check("rst_mid/late_busy", 32'(bus.cpu_busy), 32'h0);
    @(negedge clk);
    check("rst_mid/no_done", 32'(done_pulses - dn0), 32'h0);

    run_op("after_rst", 1'b0, 1'b0, 16'h0102, 16'h0000, 32'hCAFEF00D, 1, 1, 0);

    for (int n = 0; n < 40; n++) begin
      r_we     = 1'($urandom);
      r_byte   = 1'($urandom);
      r_addr   = 16'($urandom);
      r_wdata  = 16'($urandom);
      r_word   = $urandom;
      r_silent = 0;
      if ($urandom_range(0, 9) == 0) r_silent = r_we ? int'($urandom_range(1, 2)) : 1;
      run_op($sformatf("rnd%0d", n), r_we, r_byte, r_addr, r_wdata, r_word,
             int'($urandom_range(1, 8)), int'($urandom_range(1, 8)), r_silent);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
